// File: rtl/dcache_2way_top.sv
// Two-way set-associative write-back/write-allocate data cache with a per-set LRU bit.
// Define DCACHE_STATS_EN to add the hit_cnt_o / miss_cnt_o counter ports.
module dcache_2way_top #(
  parameter int INDEX_W = 4,
  parameter int ADDR_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  input  logic [255:0]      mem_data_i,
  input  logic              mem_ack_i,
  output logic [255:0]      mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
`ifdef DCACHE_STATS_EN
  output logic              mem_write_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`else
  output logic              mem_write_o
`endif
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 5;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MISS      = 3'd1;
  localparam logic [2:0] S_WRITEBACK = 3'd2;
  localparam logic [2:0] S_REFILL    = 3'd3;
  localparam logic [2:0] S_REFILLOK  = 3'd4;

  logic [2:0]         state;
  logic               victim;

  logic [TAG_W-1:0]   tag_mem  [2][SETS];
  logic [255:0]       data_mem [2][SETS];
  logic [SETS-1:0]    valid    [2];
  logic [SETS-1:0]    dirty    [2];
  logic [SETS-1:0]    lru;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [2:0]         req_word;
  logic [7:0]         bit_off;
  logic               req;
  logic [1:0]         way_hit;
  logic               hit;
  logic               acc_hit;
  logic               hit_way;
  logic [255:0]       hit_line;
  logic [255:0]       wr_line;
  logic               vsel;
  logic               unused_addr;

  assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx     = p1_addr_i[INDEX_W+4:5];
  assign req_word    = p1_addr_i[4:2];
  assign bit_off     = {req_word, 5'b0};
  assign unused_addr = ^p1_addr_i[1:0];
  assign req         = p1_MemRead_i | p1_MemWrite_i;

  always_comb begin
    way_hit[0] = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
    way_hit[1] = valid[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  end

  // A freshly refilled line only counts as a hit once back in IDLE, so the
  // stall covers the REFILLOK cycle as well.
  assign hit      = (state == S_IDLE) && (|way_hit);
  assign acc_hit  = req & hit;
  assign hit_way  = way_hit[1];
  assign hit_line = data_mem[hit_way][req_idx];

  assign p1_data_o  = hit_line[bit_off +: 32];
  assign p1_stall_o = req & ~hit;

  always_comb begin
    wr_line = hit_line;
    wr_line[bit_off +: 32] = p1_data_i;
  end

  always_comb begin
    if (!valid[0][req_idx])      vsel = 1'b0;
    else if (!valid[1][req_idx]) vsel = 1'b1;
    else                         vsel = lru[req_idx];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= S_IDLE;
      victim       <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req && !hit) state <= S_MISS;
        end
        S_MISS: begin
          victim       <= vsel;
          mem_enable_o <= 1'b1;
          if (valid[vsel][req_idx] && dirty[vsel][req_idx]) begin
            mem_write_o <= 1'b1;
            mem_addr_o  <= {tag_mem[vsel][req_idx], req_idx, 5'b0};
            mem_data_o  <= data_mem[vsel][req_idx];
            state       <= S_WRITEBACK;
          end else begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= {req_tag, req_idx, 5'b0};
            state       <= S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= {req_tag, req_idx, 5'b0};
            state       <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            state        <= S_REFILLOK;
          end
        end
        S_REFILLOK: state <= S_IDLE;
        default:    state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru      <= '0;
    end else begin
      if (acc_hit) begin
        lru[req_idx] <= ~hit_way;
        if (p1_MemWrite_i) dirty[hit_way][req_idx] <= 1'b1;
      end
      if (state == S_REFILL && mem_ack_i) begin
        valid[victim][req_idx] <= 1'b1;
        dirty[victim][req_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (state == S_REFILL && mem_ack_i) begin
      data_mem[victim][req_idx] <= mem_data_i;
      tag_mem[victim][req_idx]  <= req_tag;
    end else if (acc_hit && p1_MemWrite_i) begin
      data_mem[hit_way][req_idx] <= wr_line;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (acc_hit) hit_cnt_o <= hit_cnt_o + 32'd1;
      if (state == S_IDLE && req && !hit) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_2way_top.sv
// Directed bench for dcache_2way_top with a simple acking memory responder.
module tb_dcache_2way_top;
  logic         clk = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_2way_top #(.INDEX_W(4), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o),
`ifdef DCACHE_STATS_EN
    .mem_write_o(mem_write_o),
    .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`else
    .mem_write_o(mem_write_o)
`endif
  );

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
    return l;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    p1_addr_i = '0;
    p1_data_i = '0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    repeat (2) tick();
    #3 rst_i = 1'b1;
    tick();
  endtask

  task automatic load(input logic [31:0] a);
    p1_MemWrite_i = 1'b0;
    p1_MemRead_i = 1'b1;
    p1_addr_i = a;
  endtask

  // Waits (bounded) for a memory request, captures it, then acks after lat cycles.
  task automatic serve(input logic [255:0] line, input int lat, output bit ok,
                       output logic [31:0] a, output logic w, output logic [255:0] d);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_enable_o) ok = 1'b1;
      else tick();
    end
    a = mem_addr_o;
    w = mem_write_o;
    d = mem_data_o;
    if (ok) begin
      repeat (lat - 1) tick();
      mem_data_i = line;
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    p1_addr_i = '0;
    p1_data_i = '0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    #2;
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL reset_enable got %b want 0", mem_enable_o); end
    n_cmp++; if (mem_write_o !== 1'b0) begin n_bad++; $display("FAIL reset_write got %b want 0", mem_write_o); end
    n_cmp++; if (p1_stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall_idle got %b want 0", p1_stall_o); end
    p1_MemRead_i = 1'b1;
    p1_addr_i = 32'h0000_0404;
    #1;
    n_cmp++; if (p1_stall_o !== 1'b1) begin n_bad++; $display("FAIL reset_stall_req got %b want 1", p1_stall_o); end
`ifdef DCACHE_STATS_EN
    n_cmp++; if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin n_bad++; $display("FAIL reset_stats got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
`endif
    do_reset();
  endtask

  task automatic test_load_miss();
    logic [255:0] line, d;
    logic [31:0] a;
    logic w;
    bit ok;
    int c0;
    line = make_line(32'h1000_0000);
    line[63:32] = 32'hDEAD_BEEF;
    load(32'h0000_0404);
    c0 = cyc;
    #1;
    n_cmp++; if (p1_stall_o !== 1'b1) begin n_bad++; $display("FAIL miss_stall got %b want 1", p1_stall_o); end
    serve(line, 2, ok, a, w, d);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL miss_req_timeout got %b want 1", ok); end
    n_cmp++; if (a !== 32'h0000_0400) begin n_bad++; $display("FAIL miss_addr got %h want 00000400", a); end
    n_cmp++; if (w !== 1'b0) begin n_bad++; $display("FAIL miss_write got %b want 0", w); end
    n_cmp++; if (p1_stall_o !== 1'b1) begin n_bad++; $display("FAIL refillok_stall got %b want 1", p1_stall_o); end
    tick();
    n_cmp++; if (p1_stall_o !== 1'b0) begin n_bad++; $display("FAIL miss_done_stall got %b want 0", p1_stall_o); end
    n_cmp++; if (p1_data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL miss_data got %h want deadbeef", p1_data_o); end
    n_cmp++; if (cyc - c0 !== 5) begin n_bad++; $display("FAIL miss_latency got %0d want 5", cyc - c0); end
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL miss_enable_drop got %b want 0", mem_enable_o); end
    tick();
`ifdef DCACHE_STATS_EN
    n_cmp++; if (miss_cnt_o !== 32'd1) begin n_bad++; $display("FAIL stats_miss got %0d want 1", miss_cnt_o); end
    n_cmp++; if (hit_cnt_o !== 32'd1) begin n_bad++; $display("FAIL stats_hit got %0d want 1", hit_cnt_o); end
`endif
  endtask

  task automatic test_store_hit();
    logic [31:0] a;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b1;
    p1_addr_i = 32'h0000_0404;
    p1_data_i = 32'h1234_5678;
    #1;
    n_cmp++; if (p1_stall_o !== 1'b0) begin n_bad++; $display("FAIL store_hit_stall got %b want 0", p1_stall_o); end
    tick();
    load(32'h0000_0404);
    #1;
    n_cmp++; if (p1_data_o !== 32'h1234_5678) begin n_bad++; $display("FAIL store_readback got %h want 12345678", p1_data_o); end
    n_cmp++; if (p1_stall_o !== 1'b0) begin n_bad++; $display("FAIL store_readback_stall got %b want 0", p1_stall_o); end
    for (int i = 0; i < 8; i++) begin
      if (i != 1) begin
        a = 32'h0000_0400 + 32'(i * 4);
        p1_addr_i = a;
        #1;
        n_cmp++; if (p1_data_o !== 32'h1000_0000 + 32'(i)) begin n_bad++; $display("FAIL store_other_word%0d got %h want %h", i, p1_data_o, 32'h1000_0000 + 32'(i)); end
      end
    end
    tick();
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL store_no_traffic got %b want 0", mem_enable_o); end
  endtask

  task automatic test_two_way();
    logic [255:0] d;
    logic [31:0] a;
    logic w;
    bit ok;
    do_reset();
    load(32'h0000_0000);
    serve(make_line(32'h2000_0000), 1, ok, a, w, d);
    n_cmp++; if (ok !== 1'b1 || a !== 32'h0000_0000) begin n_bad++; $display("FAIL twoway_addr0 got %h ok=%b want 00000000", a, ok); end
    tick();
    tick();
    load(32'h0000_0200);
    serve(make_line(32'h3000_0000), 3, ok, a, w, d);
    n_cmp++; if (ok !== 1'b1 || a !== 32'h0000_0200 || w !== 1'b0) begin n_bad++; $display("FAIL twoway_addr1 got %h w=%b ok=%b want 00000200", a, w, ok); end
    tick();
    n_cmp++; if (p1_data_o !== 32'h3000_0000) begin n_bad++; $display("FAIL twoway_data1 got %h want 30000000", p1_data_o); end
    tick();
    load(32'h0000_0004);
    #1;
    n_cmp++; if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h2000_0001) begin n_bad++; $display("FAIL twoway_reread0 got %h stall=%b want 20000001", p1_data_o, p1_stall_o); end
    tick();
    load(32'h0000_021C);
    #1;
    n_cmp++; if (p1_stall_o !== 1'b0 || p1_data_o !== 32'h3000_0007) begin n_bad++; $display("FAIL twoway_reread1 got %h stall=%b want 30000007", p1_data_o, p1_stall_o); end
    tick();
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL twoway_no_traffic got %b want 0", mem_enable_o); end
  endtask

  task automatic test_dirty_evict();
    logic [255:0] d, exp_wb;
    logic [31:0] a;
    logic w;
    bit ok;
    do_reset();
    exp_wb = make_line(32'hA000_0000);
    exp_wb[31:0] = 32'hCAFE_F00D;
    p1_MemWrite_i = 1'b1;
    p1_addr_i = 32'h0000_0000;
    p1_data_i = 32'hCAFE_F00D;
    serve(make_line(32'hA000_0000), 1, ok, a, w, d);
    tick();
    n_cmp++; if (p1_stall_o !== 1'b0) begin n_bad++; $display("FAIL dirty_store_done got %b want 0", p1_stall_o); end
    tick();
    load(32'h0000_0200);
    serve(make_line(32'hB000_0000), 1, ok, a, w, d);
    tick();
    tick();
    load(32'h0000_0000);
    #1;
    n_cmp++; if (p1_stall_o !== 1'b0 || p1_data_o !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL dirty_reread got %h stall=%b want cafef00d", p1_data_o, p1_stall_o); end
    tick();
    load(32'h0000_0400);
    serve(make_line(32'hC000_0000), 2, ok, a, w, d);
    n_cmp++; if (ok !== 1'b1 || w !== 1'b0 || a !== 32'h0000_0400) begin n_bad++; $display("FAIL lru_clean_victim got %h w=%b ok=%b want 00000400 w=0", a, w, ok); end
    tick();
    tick();
    load(32'h0000_0600);
    serve(make_line(32'hD000_0000), 2, ok, a, w, d);
    n_cmp++; if (ok !== 1'b1 || w !== 1'b1 || a !== 32'h0000_0000) begin n_bad++; $display("FAIL wb_req got %h w=%b ok=%b want 00000000 w=1", a, w, ok); end
    n_cmp++; if (d !== exp_wb) begin n_bad++; $display("FAIL wb_data got %h want %h", d, exp_wb); end
    serve(make_line(32'hD000_0000), 1, ok, a, w, d);
    n_cmp++; if (ok !== 1'b1 || w !== 1'b0 || a !== 32'h0000_0600) begin n_bad++; $display("FAIL wb_refill got %h w=%b ok=%b want 00000600 w=0", a, w, ok); end
    tick();
    n_cmp++; if (p1_stall_o !== 1'b0 || p1_data_o !== 32'hD000_0000) begin n_bad++; $display("FAIL wb_load_data got %h stall=%b want d0000000", p1_data_o, p1_stall_o); end
    tick();
  endtask

  task automatic test_reset_mid_refill();
    logic [255:0] d;
    logic [31:0] a;
    logic w;
    bit ok;
    load(32'h0000_0800);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_enable_o) ok = 1'b1;
      else tick();
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midrst_req_timeout got %b want 1", ok); end
    mem_data_i = make_line(32'hE000_0000);
    mem_ack_i = 1'b1;
    #2 rst_i = 1'b0;
    #1;
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL midrst_enable_async got %b want 0", mem_enable_o); end
    tick();
    mem_ack_i = 1'b0;
    n_cmp++; if (mem_enable_o !== 1'b0) begin n_bad++; $display("FAIL midrst_enable_held got %b want 0", mem_enable_o); end
    #3 rst_i = 1'b1;
    tick();
    load(32'h0000_0400);
    #1;
    n_cmp++; if (p1_stall_o !== 1'b1) begin n_bad++; $display("FAIL midrst_miss_400 got %b want 1", p1_stall_o); end
    serve(make_line(32'hF000_0000), 1, ok, a, w, d);
    n_cmp++; if (ok !== 1'b1 || w !== 1'b0 || a !== 32'h0000_0400) begin n_bad++; $display("FAIL midrst_refill got %h w=%b ok=%b want 00000400 w=0", a, w, ok); end
    tick();
    n_cmp++; if (p1_data_o !== 32'hF000_0000) begin n_bad++; $display("FAIL midrst_data got %h want f0000000", p1_data_o); end
    tick();
    load(32'h0000_0600);
    #1;
    n_cmp++; if (p1_stall_o !== 1'b1) begin n_bad++; $display("FAIL midrst_miss_600 got %b want 1", p1_stall_o); end
  endtask

  initial begin
    test_reset();
    test_load_miss();
    test_store_hit();
    test_two_way();
    test_dirty_evict();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
